// File: rtl/flash_prog_ctrl.sv
// Configuration-flash programming controller: erases an address window sector by sector,
// then streams an image from the Rx FIFO into the ASMI primitive page by page with a
// per-page send_more handshake and a 16-bit running checksum, and finally requests
// reconfiguration.
// Build option: define FLASH_PROG_BITREV_EN to bit-reverse each byte sent to the ASMI (.rbf images).
module flash_prog_ctrl #(
    parameter int unsigned          ADDR_W       = 24,
    parameter logic [ADDR_W-1:0]    BASE_ADDR    = 24'h100000,
    parameter logic [ADDR_W-1:0]    END_ADDR     = 24'h300000,
    parameter logic [ADDR_W-1:0]    SMALL_SECTOR = 24'h010000,
    parameter logic [ADDR_W-1:0]    LARGE_SECTOR = 24'h040000,
    parameter int unsigned          PAGE_BYTES   = 256,
    parameter int unsigned          USED_W       = 11,
    parameter int unsigned          BLOCKS_W     = 14,
    parameter int unsigned          TIMEOUT      = 25000000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                erase,
    output logic                erase_ACK,
    output logic                erase_done,
    input  logic                erase_done_ACK,
    input  logic                sector_large,
    input  logic [USED_W-1:0]   fifo_used,
    input  logic [7:0]          fifo_data,
    output logic                rdreq,
    input  logic [BLOCKS_W-1:0] num_blocks,
    output logic                send_more,
    input  logic                send_more_ACK,
    output logic [15:0]         checksum,
    output logic                error,
    output logic                NCONFIG,
    output logic [ADDR_W-1:0]   asmi_addr,
    output logic                asmi_sector_erase,
    output logic                asmi_wren,
    output logic                asmi_write,
    output logic                asmi_shift_bytes,
    output logic [7:0]          asmi_datain,
    input  logic                asmi_busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW = $clog2(PAGE_BYTES) + 1;

    typedef enum logic [3:0] {
        StIdle, StEraseCmd, StEraseWait, StEraseDone, StEraseAckWait,
        StPageStart, StPageShift, StPageWrite, StPageWait, StFinalAck, StReconfig
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BLOCKS_W-1:0]   page_q, page_d;
    logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [15:0]           checksum_q, checksum_d;
    logic                  error_q, error_d;
    logic                  erase_ack_q, erase_ack_d;
    logic                  erase_done_q, erase_done_d;
    logic                  send_more_q, send_more_d;
    logic                  nconfig_q, nconfig_d;

    logic [ADDR_W-1:0]     stride;
    logic [ADDR_W:0]       erase_next, page_next, page_limit;
    logic                  fifo_ok, timed_out;
    logic [7:0]            data_out;

    assign stride     = sector_large ? LARGE_SECTOR : SMALL_SECTOR;
    assign erase_next = {1'b0, addr_q} + {1'b0, stride};
    assign page_next  = {1'b0, addr_q} + (ADDR_W + 1)'(PAGE_BYTES);
    // Last legal page start lies within the final sector beginning at END_ADDR.
    assign page_limit = {1'b0, END_ADDR} + {1'b0, stride} - 1'b1;
    assign fifo_ok    = fifo_used >= USED_W'(PAGE_BYTES - 1);
    assign timed_out  = timer_q == TW'(TIMEOUT - 1);

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            addr_q       <= BASE_ADDR;
            page_q       <= '0;
            byte_cnt_q   <= '0;
            timer_q      <= '0;
            checksum_q   <= '0;
            error_q      <= 1'b0;
            erase_ack_q  <= 1'b0;
            erase_done_q <= 1'b0;
            send_more_q  <= 1'b0;
            nconfig_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            page_q       <= page_d;
            byte_cnt_q   <= byte_cnt_d;
            timer_q      <= timer_d;
            checksum_q   <= checksum_d;
            error_q      <= error_d;
            erase_ack_q  <= erase_ack_d;
            erase_done_q <= erase_done_d;
            send_more_q  <= send_more_d;
            nconfig_q    <= nconfig_d;
        end
    end

    // Next-state logic and ASMI strobes; strobes are decoded from state so reset kills them at once.
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        page_d            = page_q;
        byte_cnt_d        = byte_cnt_q;
        timer_d           = timer_q;
        checksum_d        = checksum_q;
        error_d           = error_q;
        erase_ack_d       = erase_ack_q;
        erase_done_d      = erase_done_q;
        send_more_d       = send_more_q;
        nconfig_d         = nconfig_q;
        rdreq             = 1'b0;
        asmi_wren         = 1'b0;
        asmi_sector_erase = 1'b0;
        asmi_write        = 1'b0;
        asmi_shift_bytes  = 1'b0;
        unique case (state_q)
            StIdle: begin
                erase_ack_d  = 1'b0;
                erase_done_d = 1'b0;
                send_more_d  = 1'b0;
                checksum_d   = '0;
                page_d       = '0;
                addr_d       = BASE_ADDR;
                if (erase) begin
                    state_d = StEraseCmd;
                end else if (fifo_ok && num_blocks != '0) begin
                    state_d = StPageStart;
                end
            end
            StEraseCmd: begin
                erase_ack_d       = 1'b1;
                asmi_wren         = 1'b1;
                asmi_sector_erase = 1'b1;
                state_d           = StEraseWait;
            end
            StEraseWait: begin
                if (!asmi_busy) begin
                    if (addr_q == END_ADDR) begin
                        state_d = StEraseDone;
                    end else if (erase_next > {1'b0, END_ADDR}) begin
                        // Stride would step past END_ADDR without landing on it.
                        error_d = 1'b1;
                        state_d = StEraseDone;
                    end else begin
                        addr_d  = erase_next[ADDR_W-1:0];
                        state_d = StEraseCmd;
                    end
                end
            end
            StEraseDone: begin
                erase_done_d = 1'b1;
                timer_d      = '0;
                state_d      = StEraseAckWait;
            end
            StEraseAckWait: begin
                timer_d = timer_q + 1'b1;
                if (erase_done_ACK) begin
                    state_d = StIdle;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StPageStart: begin
                byte_cnt_d = '0;
                state_d    = StPageShift;
            end
            StPageShift: begin
                asmi_wren = 1'b1;
                // Show-ahead FIFO: the head byte is consumed in the same cycle it is popped.
                if (byte_cnt_q < CW'(PAGE_BYTES)) begin
                    rdreq            = 1'b1;
                    asmi_shift_bytes = 1'b1;
                    checksum_d       = checksum_q + {8'h00, fifo_data};
                    byte_cnt_d       = byte_cnt_q + 1'b1;
                end else begin
                    page_d  = page_q + 1'b1;
                    state_d = StPageWrite;
                end
            end
            StPageWrite: begin
                asmi_wren   = 1'b1;
                asmi_write  = 1'b1;
                send_more_d = 1'b1;
                timer_d     = '0;
                state_d     = StPageWait;
            end
            StPageWait: begin
                timer_d = timer_q + 1'b1;
                if (send_more_ACK) begin
                    send_more_d = 1'b0;
                end
                if (page_q == num_blocks) begin
                    // Last page: keep send_more high as the final-page report.
                    send_more_d = 1'b1;
                    timer_d     = '0;
                    state_d     = StFinalAck;
                end else if (!send_more_q && !asmi_busy && fifo_ok) begin
                    if (page_next > page_limit) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        addr_d  = page_next[ADDR_W-1:0];
                        state_d = StPageStart;
                    end
                end else if (send_more_q && timed_out) begin
                    error_d     = 1'b1;
                    send_more_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StFinalAck: begin
                timer_d = timer_q + 1'b1;
                if (send_more_ACK) begin
                    send_more_d = 1'b0;
                    timer_d     = '0;
                    state_d     = StReconfig;
                end else if (timed_out) begin
                    error_d     = 1'b1;
                    send_more_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StReconfig: begin
                // Terminal: only reset leaves this state.
                if (timer_q != TW'(TIMEOUT)) begin
                    timer_d = timer_q + 1'b1;
                end else if (!asmi_busy) begin
                    nconfig_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Byte presented to the ASMI; held at zero when not shifting.
    always_comb begin
        data_out = fifo_data;
`ifdef FLASH_PROG_BITREV_EN
        for (int i = 0; i < 8; i++) begin
            data_out[i] = fifo_data[7-i];
        end
`endif
        asmi_datain = asmi_shift_bytes ? data_out : 8'h00;
    end

    assign asmi_addr  = addr_q;
    assign checksum   = checksum_q;
    assign error      = error_q;
    assign erase_ACK  = erase_ack_q;
    assign erase_done = erase_done_q;
    assign send_more  = send_more_q;
    assign NCONFIG    = nconfig_q;

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Directed self-checking bench for flash_prog_ctrl with small FIFO and ASMI behavioural models.
module tb_flash_prog_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        erase, erase_ACK, erase_done, erase_done_ACK, sector_large;
    logic [10:0] fifo_used;
    logic [7:0]  fifo_data;
    logic        rdreq;
    logic [13:0] num_blocks;
    logic        send_more, send_more_ACK;
    logic [15:0] checksum;
    logic        error, NCONFIG;
    logic [23:0] asmi_addr;
    logic        asmi_sector_erase, asmi_wren, asmi_write, asmi_shift_bytes;
    logic [7:0]  asmi_datain;
    logic        asmi_busy;

    int total = 0;
    int bad   = 0;

    // Model state
    logic        clr_stats;
    logic [15:0] fifo_idx;
    logic [2:0]  busy_cnt;
    int          erase_pulses, writes, rd_cnt, rd_page0, rd_page1;
    logic        erase_addr_err;
    logic [23:0] w_addr0, w_addr1;
    logic [7:0]  exp_one;

    always #5 clock = ~clock;

    flash_prog_ctrl #(.TIMEOUT(100)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .erase             (erase),
        .erase_ACK         (erase_ACK),
        .erase_done        (erase_done),
        .erase_done_ACK    (erase_done_ACK),
        .sector_large      (sector_large),
        .fifo_used         (fifo_used),
        .fifo_data         (fifo_data),
        .rdreq             (rdreq),
        .num_blocks        (num_blocks),
        .send_more         (send_more),
        .send_more_ACK     (send_more_ACK),
        .checksum          (checksum),
        .error             (error),
        .NCONFIG           (NCONFIG),
        .asmi_addr         (asmi_addr),
        .asmi_sector_erase (asmi_sector_erase),
        .asmi_wren         (asmi_wren),
        .asmi_write        (asmi_write),
        .asmi_shift_bytes  (asmi_shift_bytes),
        .asmi_datain       (asmi_datain),
        .asmi_busy         (asmi_busy)
    );

    assign fifo_data = fifo_idx[7:0];
    assign asmi_busy = busy_cnt != 3'd0;

    // Show-ahead FIFO holding an incrementing byte pattern, and an ASMI that is busy 3 cycles per command.
    always @(posedge clock) begin
        if (clr_stats) begin
            fifo_idx       <= '0;
            busy_cnt       <= '0;
            erase_pulses   <= 0;
            erase_addr_err <= 1'b0;
            writes         <= 0;
            rd_cnt         <= 0;
            rd_page0       <= 0;
            rd_page1       <= 0;
            w_addr0        <= '0;
            w_addr1        <= '0;
        end else begin
            if (rdreq) begin
                fifo_idx <= fifo_idx + 16'd1;
                rd_cnt   <= rd_cnt + 1;
            end
            if (asmi_sector_erase) begin
                if (asmi_addr != 24'h100000 + 24'(erase_pulses) * 24'h010000) begin
                    erase_addr_err <= 1'b1;
                end
                erase_pulses <= erase_pulses + 1;
            end
            if (asmi_write) begin
                if (writes == 0) begin
                    w_addr0  <= asmi_addr;
                    rd_page0 <= rd_cnt;
                end else begin
                    w_addr1  <= asmi_addr;
                    rd_page1 <= rd_cnt;
                end
                writes <= writes + 1;
                rd_cnt <= 0;
            end
            if (asmi_sector_erase || asmi_write) begin
                busy_cnt <= 3'd3;
            end else if (busy_cnt != 3'd0) begin
                busy_cnt <= busy_cnt - 3'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        clr_stats      = 1'b1;
        erase          = 1'b0;
        erase_done_ACK = 1'b0;
        sector_large   = 1'b0;
        fifo_used      = '0;
        num_blocks     = '0;
        send_more_ACK  = 1'b0;
        repeat (2) @(negedge clock);
        clr_stats = 1'b0;
        reset_n   = 1'b1;
        @(negedge clock);
    endtask

    initial begin
`ifdef FLASH_PROG_BITREV_EN
        exp_one = 8'h80;
`else
        exp_one = 8'h01;
`endif
        // Reset state
        do_reset();
        check("rst_rdreq", rdreq, 0);
        check("rst_wren", asmi_wren, 0);
        check("rst_nconfig", NCONFIG, 0);
        check("rst_addr", asmi_addr, 24'h100000);
        check("rst_error", error, 0);
        check("rst_checksum", checksum, 0);

        // Erase of the full window with small sectors
        erase = 1'b1;
        for (int i = 0; i < 20 && !erase_ACK; i++) @(negedge clock);
        check("erase_ack", erase_ACK, 1);
        erase = 1'b0;
        for (int i = 0; i < 2000 && !erase_done; i++) @(negedge clock);
        check("erase_done", erase_done, 1);
        check("erase_pulses", erase_pulses, 33);
        check("erase_addr_err", erase_addr_err, 0);
        erase_done_ACK = 1'b1;
        @(negedge clock);
        erase_done_ACK = 1'b0;
        @(negedge clock);
        check("erase_done_clr", erase_done, 0);
        check("erase_error", error, 0);

        // Two-page program, then reconfiguration
        do_reset();
        num_blocks = 14'd2;
        fifo_used  = 11'd300;
        for (int i = 0; i < 2000 && !send_more; i++) @(negedge clock);
        check("p1_send_more", send_more, 1);
        send_more_ACK = 1'b1;
        for (int i = 0; i < 50 && send_more; i++) @(negedge clock);
        send_more_ACK = 1'b0;
        for (int i = 0; i < 2000 && !send_more; i++) @(negedge clock);
        check("p2_send_more", send_more, 1);
        send_more_ACK = 1'b1;
        for (int i = 0; i < 50 && send_more; i++) @(negedge clock);
        send_more_ACK = 1'b0;
        check("final_ack_drop", send_more, 0);
        check("writes", writes, 2);
        check("rd_page0", rd_page0, 256);
        check("rd_page1", rd_page1, 256);
        check("w_addr0", w_addr0, 24'h100000);
        check("w_addr1", w_addr1, 24'h100100);
        check("checksum", checksum, 16'hFF00);
        repeat (100) @(negedge clock);
        check("nconfig_early", NCONFIG, 0);
        @(negedge clock);
        check("nconfig", NCONFIG, 1);
        check("prog_error", error, 0);

        // ACK withheld after page 1
        do_reset();
        num_blocks = 14'd2;
        fifo_used  = 11'd300;
        for (int i = 0; i < 2000 && !asmi_write; i++) @(negedge clock);
        check("to_write", asmi_write, 1);
        fifo_used = '0;
        repeat (100) @(negedge clock);
        check("to_error_before", error, 0);
        @(negedge clock);
        check("to_error", error, 1);
        check("to_send_more", send_more, 0);
        repeat (5) @(negedge clock);
        check("to_rdreq", rdreq, 0);

        // Zero-length image never programs
        do_reset();
        num_blocks = '0;
        fifo_used  = 11'd300;
        repeat (300) @(negedge clock);
        check("nb0_reads", rd_cnt, 0);
        check("nb0_writes", writes, 0);

        // Reset asserted in the middle of a page shift
        do_reset();
        num_blocks = 14'd1;
        fifo_used  = 11'd300;
        for (int i = 0; i < 200 && !rdreq; i++) @(negedge clock);
        check("mid_rdreq", rdreq, 1);
        @(negedge clock);
        check("datain_byte1", asmi_datain, exp_one);
        repeat (99) @(negedge clock);
        check("mid_checksum", checksum, 16'h1356);
        reset_n = 1'b0;
        #1;
        check("mr_rdreq", rdreq, 0);
        check("mr_wren", asmi_wren, 0);
        check("mr_shift", asmi_shift_bytes, 0);
        check("mr_write", asmi_write, 0);
        check("mr_erase", asmi_sector_erase, 0);
        check("mr_send_more", send_more, 0);
        check("mr_checksum", checksum, 0);
        check("mr_addr", asmi_addr, 24'h100000);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
